// File: rtl/hamming_counter_pkg.sv
// hamming_counter_pkg
//   Shared widths, codeword layout and SECDED helper functions for the
//   Hamming-counter macro.
//   Codeword layout: counter[i-1] holds Hamming position i (1..15);
//   parity at positions 1, 2, 4, 8; bit 15 is overall (even) parity.
package hamming_counter_pkg;

   localparam int unsigned DATA_W = 11;
   localparam int unsigned CODE_W = 16;

   // Codeword position (1-based) of data bit d0..d10.
   localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

   typedef struct packed {
      logic [3:0] syn;      // Hamming syndrome over positions 1..15
      logic       par_err;  // overall parity is odd
   } hamming_syn_t;

   function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
      logic [CODE_W-1:0] cw;
      logic              p;
      cw = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         cw[DATA_POS[i]-1] = data[i];
      end
      // Parity positions never cover each other, so each p_k can be
      // computed straight from the partially filled word.
      for (int unsigned k = 0; k < 4; k++) begin
         p = 1'b0;
         for (int unsigned pos = 1; pos < 16; pos++) begin
            if (pos[k]) p ^= cw[pos-1];
         end
         cw[(1 << k) - 1] = p;
      end
      cw[CODE_W-1] = ^cw[CODE_W-2:0];
      return cw;
   endfunction

   function automatic hamming_syn_t hamming_syndrome(input logic [CODE_W-1:0] cw);
      hamming_syn_t r;
      logic         s;
      r = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         s = 1'b0;
         for (int unsigned pos = 1; pos < 16; pos++) begin
            if (pos[k]) s ^= cw[pos-1];
         end
         r.syn[k] = s;
      end
      r.par_err = ^cw;
      return r;
   endfunction

endpackage

// File: rtl/hamming_counter_enc.sv
// hamming_enc
//   Purely combinational 11-bit to 16-bit extended Hamming (SECDED) encoder.
//   Ports:
//     data  input  [DATA_W-1:0]  value to encode
//     code  output [CODE_W-1:0]  SECDED codeword
module hamming_enc
   import hamming_counter_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CODE_W-1:0] code
);

   always_comb begin
      code = hamming_encode(data);
   end

endmodule

// File: rtl/hamming_counter.sv
// hamming_counter
//   Free-running 11-bit up-counter presented only as a registered 16-bit
//   SECDED codeword. Wraps 2047 -> 0 silently.
//   Ports:
//     clk      input       rising-edge clock
//     rst      input       synchronous reset, active-low (priority over enable)
//     enable   input       count enable, active-high
//     counter  output [16] registered codeword of the current count
//   Build option:
//     HAMMING_SEC_EN  when defined, the codeword register is the only state;
//                     single-bit errors are corrected every cycle and a
//                     double-bit error reloads zero on an enabled edge.
module hamming_counter
   import hamming_counter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [CODE_W-1:0] counter
);

   logic [CODE_W-1:0] code;
   logic [DATA_W-1:0] enc_in;
   logic [CODE_W-1:0] enc_out;

   hamming_enc u_enc (
      .data (enc_in),
      .code (enc_out)
   );

`ifdef HAMMING_SEC_EN

   hamming_syn_t      st;
   logic [CODE_W-1:0] fixed;
   logic [DATA_W-1:0] data;
   logic              dbl;

   // Decode/correct the stored word; the encoder then rebuilds either the
   // incremented value or, when idle, the corrected word in place.
   always_comb begin
      st    = hamming_syndrome(code);
      fixed = code;
      dbl   = 1'b0;
      data  = '0;
      if (st.par_err) begin
         if (st.syn == 4'd0) fixed[CODE_W-1] = ~fixed[CODE_W-1];
         else                fixed[4'(st.syn - 4'd1)] = ~fixed[4'(st.syn - 4'd1)];
      end else if (st.syn != 4'd0) begin
         dbl = 1'b1;
      end
      for (int unsigned i = 0; i < DATA_W; i++) begin
         data[i] = fixed[DATA_POS[i]-1];
      end
      enc_in = enable ? data + DATA_W'(1) : data;
   end

   // An uncorrectable word is held while idle and cleared on the next
   // enabled edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         code <= '0;
      end else if (dbl) begin
         if (enable) code <= '0;
      end else begin
         code <= enc_out;
      end
   end

`else

   logic [DATA_W-1:0] cnt;

   always_comb begin
      enc_in = cnt + DATA_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt  <= '0;
         code <= '0;
      end else if (enable) begin
         cnt  <= enc_in;
         code <= enc_out;
      end
   end

`endif

   assign counter = code;

endmodule

// File: tb/tb_hamming_counter.sv
module tb_hamming_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] counter;

   int checks = 0;
   int errors = 0;
   int mcnt   = 0;

   hamming_counter dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .counter (counter)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        e;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Reference encoder: data bits fill the non-power-of-two positions in
   // order; each parity is the count of covered ones modulo 2.
   function automatic logic [15:0] ref_encode(input int v);
      logic [15:0] cw;
      int di;
      int ones;
      cw = '0;
      di = 0;
      for (int p = 1; p < 16; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = 1'((v >> di) & 1);
            di++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         ones = 0;
         for (int p = 1; p < 16; p++) begin
            if ((((p >> k) & 1) == 1) && ((p & (p - 1)) != 0)) ones += int'(cw[p-1]);
         end
         cw[(1 << k) - 1] = 1'(ones % 2);
      end
      cw[15] = 1'($countones(cw[14:0]) % 2);
      return cw;
   endfunction

   // Syndrome as XOR of the indices of all set bits in positions 1..15.
   function automatic int idx_xor(input logic [15:0] cw);
      int s;
      s = 0;
      for (int p = 1; p < 16; p++) if (cw[p-1]) s ^= p;
      return s;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: counter=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic check_code(input string name);
      checks++;
      if (idx_xor(counter) != 0 || ($countones(counter) % 2) != 0) begin
         errors++;
         $display("FAIL %s: counter=%h syndrome=%0d ones=%0d expected syndrome 0, even ones",
                  name, counter, idx_xor(counter), $countones(counter));
      end
   endtask

   task automatic tick(input logic r, input logic e);
      @(negedge clk);
      rst    = r;
      enable = e;
      @(posedge clk);
      #1;
      if (!r)     mcnt = 0;
      else if (e) mcnt = (mcnt + 1) % 2048;
   endtask

`ifdef HAMMING_SEC_EN
   logic [15:0] fv;
   task automatic flip(input logic [15:0] base, input logic [15:0] mask);
      fv = base ^ mask;
      force dut.code = fv;
      #1;
      release dut.code;
   endtask
`endif

   initial begin
      int guard;

      // Reset with enable high, then held.
      tick(1'b0, 1'b1);
      check("reset", counter, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1);
         check("reset_hold", counter, 16'h0000);
      end

      // Count / hold / further-count table.
      vecs.push_back('{1'b1, 1'b1, 16'h8007});
      vecs.push_back('{1'b1, 1'b1, 16'h8019});
      vecs.push_back('{1'b1, 1'b1, 16'h001E});
      for (int i = 0; i < 9; i++) vecs.push_back('{1'b1, 1'b0, 16'h001E});
      vecs.push_back('{1'b1, 1'b1, 16'h802A});
      for (int n = 5; n < 8; n++) vecs.push_back('{1'b1, 1'b1, ref_encode(n)});
      vecs.push_back('{1'b1, 1'b1, 16'h004B});
      for (int i = 0; i < vecs.size(); i++) begin
         tick(vecs[i].r, vecs[i].e);
         check($sformatf("table[%0d]", i), counter, vecs[i].exp);
         check("table_ref", counter, ref_encode(mcnt));
         check_code("table_code");
      end

      // Run up to the wrap point.
      guard = 0;
      while (mcnt != 2047 && guard < 3000) begin
         tick(1'b1, 1'b1);
         check("run", counter, ref_encode(mcnt));
         guard++;
      end
      check("max_2047", counter, 16'hFFFF);
      tick(1'b1, 1'b1);
      check("wrap_0", counter, 16'h0000);
      tick(1'b1, 1'b1);
      check("after_wrap", counter, 16'h8007);

      // Random enable with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom % 100) != 0, ($urandom % 4) != 0);
         check("random", counter, ref_encode(mcnt));
         check_code("random_code");
      end

      // Reset mid-count with enable high, then resume from 0.
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      check("mid_reset", counter, 16'h0000);
      tick(1'b1, 1'b0);
      check("post_reset_idle", counter, 16'h0000);
      tick(1'b1, 1'b1);
      check("resume", counter, 16'h8007);

`ifdef HAMMING_SEC_EN
      tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
      check("sec_cnt3", counter, 16'h001E);
      flip(16'h001E, 16'h0040);
      tick(1'b1, 1'b1);
      check("sec_single", counter, 16'h802A);
      flip(16'h802A, 16'h0004);
      tick(1'b1, 1'b0);
      check("sec_idle_fix", counter, 16'h802A);
      flip(16'h802A, 16'h8000);
      tick(1'b1, 1'b1);
      check("sec_par_bit", counter, ref_encode(5));
      flip(ref_encode(5), 16'h0101);
      tick(1'b1, 1'b1);
      mcnt = 0;
      check("sec_double", counter, 16'h0000);
      tick(1'b1, 1'b1);
      check("sec_after_double", counter, 16'h8007);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
